alu_rs: RTL and testbench

Reservation station for the integer ALU in the out-of-order backend. Buffers dispatched ALU, branch and jump micro-ops, captures missing source operands from the two writeback broadcast buses, and issues one ready micro-op per cycle into the combinational `ALU`. A flush clears the station on a mispredict reported by the ALU.

---
 rtl/alu_rs_pkg.sv | 65 ++++++
 rtl/alu_rs_if.sv | 56 +++++
 rtl/alu_rs_select.sv | 46 ++++
 rtl/alu_rs.sv | 126 ++++++++++++
 tb/tb_alu_rs.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types for the integer ALU reservation station: entry/source structs, opcodes, wakeup helper.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Optional feature macro: ALU_RS_AGE_SELECT_EN adds an age field to rs_entry_t.
package alu_rs_pkg;

   // Major opcodes, inst[6:2]; shared with decode.
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   // Storage width of the age field; only the low $clog2(RS_DEPTH) bits ever count.
   localparam int AGE_STORE_W = 8;

   typedef struct packed {
      logic [6:0]  tag;
      logic        rdy;
      logic [31:0] data;
   } rs_src_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [2:0]  rob_idx;
      logic [6:0]  rd;
      rs_src_t     src1;
      rs_src_t     src2;
`ifdef ALU_RS_AGE_SELECT_EN
      logic [AGE_STORE_W-1:0] age;
`endif
   } rs_entry_t;

   // Capture a broadcast into a waiting source; wb0 has priority when both buses hit the same tag.
   function automatic rs_src_t src_wakeup(input rs_src_t     s,
                                          input logic        wb0_valid,
                                          input logic [6:0]  wb0_rd,
                                          input logic [31:0] wb0_data,
                                          input logic        wb1_valid,
                                          input logic [6:0]  wb1_rd,
                                          input logic [31:0] wb1_data);
      rs_src_t r;
      r = s;
      if (!s.rdy) begin
         if (wb0_valid && wb0_rd == s.tag) begin
            r.rdy  = 1'b1;
            r.data = wb0_data;
         end else if (wb1_valid && wb1_rd == s.tag) begin
            r.rdy  = 1'b1;
            r.data = wb1_data;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, writeback broadcast, flush and issue bundle between backend and the ALU reservation station.
// Latency: n/a (wires only).
// Backpressure: disp_valid/disp_ready handshake on dispatch; issue and broadcasts are never stalled.
// Modports: master = dispatch/writeback/flush driver, slave = reservation station.
interface alu_rs_if;
   logic        disp_valid;
   logic        disp_ready;
   logic [4:0]  disp_opcode;
   logic [2:0]  disp_funct3;
   logic        disp_funct7;
   logic [31:0] disp_imm;
   logic [31:0] disp_pc;
   logic [2:0]  disp_rob_idx;
   logic [6:0]  disp_rd;
   logic [6:0]  disp_rs1_tag;
   logic        disp_rs1_rdy;
   logic [31:0] disp_rs1_data;
   logic [6:0]  disp_rs2_tag;
   logic        disp_rs2_rdy;
   logic [31:0] disp_rs2_data;
   logic        wb0_valid;
   logic [6:0]  wb0_rd;
   logic [31:0] wb0_data;
   logic        wb1_valid;
   logic [6:0]  wb1_rd;
   logic [31:0] wb1_data;
   logic        flush;
   logic        iss_valid;
   logic [4:0]  iss_opcode;
   logic [2:0]  iss_funct3;
   logic        iss_funct7;
   logic [31:0] iss_rs1_data;
   logic [31:0] iss_rs2_data;
   logic [31:0] iss_imm;
   logic [31:0] iss_pc;
   logic [2:0]  iss_rob_idx;
   logic [6:0]  iss_rd;

   modport master (
      output disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc,
             disp_rob_idx, disp_rd, disp_rs1_tag, disp_rs1_rdy, disp_rs1_data,
             disp_rs2_tag, disp_rs2_rdy, disp_rs2_data,
             wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data, flush,
      input  disp_ready, iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_rs1_data,
             iss_rs2_data, iss_imm, iss_pc, iss_rob_idx, iss_rd
   );

   modport slave (
      input  disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_imm, disp_pc,
             disp_rob_idx, disp_rd, disp_rs1_tag, disp_rs1_rdy, disp_rs1_data,
             disp_rs2_tag, disp_rs2_rdy, disp_rs2_data,
             wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data, flush,
      output disp_ready, iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_rs1_data,
             iss_rs2_data, iss_imm, iss_pc, iss_rob_idx, iss_rd
   );
endinterface

// File: rtl/alu_rs_select.sv
// Issue picker: one-hot grant over eligible entries (oldest first with ALU_RS_AGE_SELECT_EN, else lowest index).
// Latency: combinational.
// Backpressure: none; a grant is produced whenever any entry is eligible.
// Ports: elig (eligibility vector), age (per-entry age, macro builds only), grant (one-hot), gnt_valid.
module alu_rs_select #(
   parameter int RS_DEPTH = 4
) (
   input  logic [RS_DEPTH-1:0]                        elig,
`ifdef ALU_RS_AGE_SELECT_EN
   input  logic [RS_DEPTH-1:0][$clog2(RS_DEPTH)-1:0] age,
`endif
   output logic [RS_DEPTH-1:0]                        grant,
   output logic                                       gnt_valid
);

`ifdef ALU_RS_AGE_SELECT_EN
   logic [$clog2(RS_DEPTH)-1:0] best_age;

   // Strict '>' keeps the lowest index on an age tie.
   always_comb begin
      grant     = '0;
      gnt_valid = 1'b0;
      best_age  = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (elig[i] && (!gnt_valid || age[i] > best_age)) begin
            grant     = '0;
            grant[i]  = 1'b1;
            gnt_valid = 1'b1;
            best_age  = age[i];
         end
      end
   end
`else
   always_comb begin
      grant     = '0;
      gnt_valid = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (elig[i] && !gnt_valid) begin
            grant[i]  = 1'b1;
            gnt_valid = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers ALU/branch/jump uops, wakes sources from wb0/wb1, issues one per cycle.
// Latency: dispatch-to-issue >= 1 cycle; broadcast-to-issue >= 1 cycle (no same-cycle wakeup-to-issue path).
// Backpressure: disp_ready from registered occupancy only; issue never stalls (ALU always accepts).
// Ports: clk, rst_n (async, active-low), rs (alu_rs_if.slave). Optional: ALU_RS_AGE_SELECT_EN (oldest-first select).
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_DEPTH = 4
) (
   input logic    clk,
   input logic    rst_n,
   alu_rs_if.slave rs
);

   localparam int IDX_W = $clog2(RS_DEPTH);

   rs_entry_t           ent [RS_DEPTH];
   rs_entry_t           new_ent;
   rs_entry_t           sel;
   logic [RS_DEPTH-1:0] elig;
   logic [RS_DEPTH-1:0] free;
   logic [RS_DEPTH-1:0] grant;
   logic                gnt_valid;
   logic [IDX_W-1:0]    free_idx;
   logic                disp_fire;

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         elig[i] = ent[i].valid && ent[i].src1.rdy && ent[i].src2.rdy;
         free[i] = !ent[i].valid;
      end
   end

   // Registered state only, so a same-cycle issue cannot make room for a same-cycle dispatch.
   assign rs.disp_ready = |free;
   assign disp_fire     = rs.disp_valid && rs.disp_ready;

   always_comb begin
      free_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (free[i]) free_idx = IDX_W'(i);
      end
   end

   // Incoming uop; sources that miss a same-cycle broadcast are bypassed here.
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.opcode  = rs.disp_opcode;
      new_ent.funct3  = rs.disp_funct3;
      new_ent.funct7  = rs.disp_funct7;
      new_ent.imm     = rs.disp_imm;
      new_ent.pc      = rs.disp_pc;
      new_ent.rob_idx = rs.disp_rob_idx;
      new_ent.rd      = rs.disp_rd;
      new_ent.src1    = src_wakeup('{tag: rs.disp_rs1_tag, rdy: rs.disp_rs1_rdy, data: rs.disp_rs1_data},
                                   rs.wb0_valid, rs.wb0_rd, rs.wb0_data,
                                   rs.wb1_valid, rs.wb1_rd, rs.wb1_data);
      new_ent.src2    = src_wakeup('{tag: rs.disp_rs2_tag, rdy: rs.disp_rs2_rdy, data: rs.disp_rs2_data},
                                   rs.wb0_valid, rs.wb0_rd, rs.wb0_data,
                                   rs.wb1_valid, rs.wb1_rd, rs.wb1_data);
   end

`ifdef ALU_RS_AGE_SELECT_EN
   logic [RS_DEPTH-1:0][IDX_W-1:0] age_vec;

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) age_vec[i] = ent[i].age[IDX_W-1:0];
   end
`endif

   alu_rs_select #(.RS_DEPTH(RS_DEPTH)) u_select (
      .elig      (elig),
`ifdef ALU_RS_AGE_SELECT_EN
      .age       (age_vec),
`endif
      .grant     (grant),
      .gnt_valid (gnt_valid)
   );

   // One-hot mux; all-zero when nothing is granted so iss_* idle at 0.
   always_comb begin
      sel = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (grant[i]) sel = ent[i];
      end
   end

   assign rs.iss_valid    = gnt_valid;
   assign rs.iss_opcode   = sel.opcode;
   assign rs.iss_funct3   = sel.funct3;
   assign rs.iss_funct7   = sel.funct7;
   assign rs.iss_rs1_data = sel.src1.data;
   assign rs.iss_rs2_data = sel.src2.data;
   assign rs.iss_imm      = sel.imm;
   assign rs.iss_pc       = sel.pc;
   assign rs.iss_rob_idx  = sel.rob_idx;
   assign rs.iss_rd       = sel.rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
      end else if (rs.flush) begin
         // Dispatch and wakeup in the flush cycle are dropped along with every entry.
         for (int i = 0; i < RS_DEPTH; i++) ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
               ent[i].valid <= 1'b0;
            end else if (ent[i].valid) begin
               ent[i].src1 <= src_wakeup(ent[i].src1, rs.wb0_valid, rs.wb0_rd, rs.wb0_data,
                                         rs.wb1_valid, rs.wb1_rd, rs.wb1_data);
               ent[i].src2 <= src_wakeup(ent[i].src2, rs.wb0_valid, rs.wb0_rd, rs.wb0_data,
                                         rs.wb1_valid, rs.wb1_rd, rs.wb1_data);
`ifdef ALU_RS_AGE_SELECT_EN
               if (ent[i].age[IDX_W-1:0] != {IDX_W{1'b1}})
                  ent[i].age <= ent[i].age + AGE_STORE_W'(1);
`endif
            end else if (disp_fire && free_idx == IDX_W'(i)) begin
               ent[i] <= new_ent;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: dispatch/issue latency, wakeup, bypass, full station, flush, select order, async reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_rs;
   import alu_rs_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   alu_rs_if bus ();

   alu_rs #(.RS_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rs    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.disp_valid    = 1'b0;
      bus.disp_opcode   = '0;
      bus.disp_funct3   = '0;
      bus.disp_funct7   = 1'b0;
      bus.disp_imm      = '0;
      bus.disp_pc       = '0;
      bus.disp_rob_idx  = '0;
      bus.disp_rd       = '0;
      bus.disp_rs1_tag  = '0;
      bus.disp_rs1_rdy  = 1'b0;
      bus.disp_rs1_data = '0;
      bus.disp_rs2_tag  = '0;
      bus.disp_rs2_rdy  = 1'b0;
      bus.disp_rs2_data = '0;
      bus.wb0_valid     = 1'b0;
      bus.wb0_rd        = '0;
      bus.wb0_data      = '0;
      bus.wb1_valid     = 1'b0;
      bus.wb1_rd        = '0;
      bus.wb1_data      = '0;
      bus.flush         = 1'b0;
   endtask

   // Outputs are sampled 1 ns after the edge; inputs for the new cycle are driven right after.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic disp(input logic [2:0] rob, input logic [4:0] opc, input logic [31:0] imm,
                       input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [6:0] t2, input logic r2, input logic [31:0] d2);
      bus.disp_valid    = 1'b1;
      bus.disp_opcode   = opc;
      bus.disp_funct3   = 3'd0;
      bus.disp_funct7   = 1'b0;
      bus.disp_imm      = imm;
      bus.disp_pc       = 32'h1000 + {29'd0, rob} * 4;
      bus.disp_rob_idx  = rob;
      bus.disp_rd       = 7'h50 + {4'd0, rob};
      bus.disp_rs1_tag  = t1;
      bus.disp_rs1_rdy  = r1;
      bus.disp_rs1_data = d1;
      bus.disp_rs2_tag  = t2;
      bus.disp_rs2_rdy  = r2;
      bus.disp_rs2_data = d2;
   endtask

   task automatic wb0(input logic [6:0] rd, input logic [31:0] data);
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = rd;
      bus.wb0_data  = data;
   endtask

   task automatic wb1(input logic [6:0] rd, input logic [31:0] data);
      bus.wb1_valid = 1'b1;
      bus.wb1_rd    = rd;
      bus.wb1_data  = data;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idle();
      rst_n = 1'b0;
      #12;
      chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
      chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
      chk("rst_iss_rs1", bus.iss_rs1_data, 32'd0);
      chk("rst_iss_pc", bus.iss_pc, 32'd0);
      rst_n = 1'b1;
      tick();

      // ADDI x, 5 + 3
      disp(3'd1, OPC_OP_IMM, 32'd3, 7'h01, 1'b1, 32'd5, 7'h00, 1'b1, 32'd0);
      chk("addi_no_same_cycle", 32'(bus.iss_valid), 32'd0);
      tick();
      chk("addi_iss_valid", 32'(bus.iss_valid), 32'd1);
      chk("addi_rs1", bus.iss_rs1_data, 32'd5);
      chk("addi_imm", bus.iss_imm, 32'd3);
      chk("addi_rob", 32'(bus.iss_rob_idx), 32'd1);
      chk("addi_opcode", 32'(bus.iss_opcode), 32'(OPC_OP_IMM));
      chk("addi_pc", bus.iss_pc, 32'h1004);
      chk("addi_rd", 32'(bus.iss_rd), 32'h51);
      tick();
      chk("addi_empty", 32'(bus.iss_valid), 32'd0);
      chk("empty_rob_zero", 32'(bus.iss_rob_idx), 32'd0);

      // ADD waiting on rs2 tag 0x12, woken by wb1
      disp(3'd2, OPC_OP, 32'd0, 7'h03, 1'b1, 32'h11, 7'h12, 1'b0, 32'd0);
      tick();
      chk("add_wait", 32'(bus.iss_valid), 32'd0);
      wb1(7'h12, 32'hDEAD);
      chk("add_no_wake_issue", 32'(bus.iss_valid), 32'd0);
      tick();
      chk("add_iss_valid", 32'(bus.iss_valid), 32'd1);
      chk("add_rs2", bus.iss_rs2_data, 32'hDEAD);
      chk("add_rs1", bus.iss_rs1_data, 32'h11);
      chk("add_rob", 32'(bus.iss_rob_idx), 32'd2);
      tick();

      // Both buses hit the same tag: wb0 data must win
      disp(3'd3, OPC_OP, 32'd0, 7'h15, 1'b0, 32'd0, 7'h04, 1'b1, 32'h4);
      tick();
      wb0(7'h15, 32'hA0);
      wb1(7'h15, 32'hB1);
      tick();
      chk("wb_prio_valid", 32'(bus.iss_valid), 32'd1);
      chk("wb_prio_rs1", bus.iss_rs1_data, 32'hA0);
      tick();

      // Dispatch bypass from same-cycle wb0
      disp(3'd4, OPC_OP_IMM, 32'd9, 7'h20, 1'b0, 32'd0, 7'h00, 1'b1, 32'd0);
      wb0(7'h20, 32'd7);
      tick();
      chk("bypass_valid", 32'(bus.iss_valid), 32'd1);
      chk("bypass_rs1", bus.iss_rs1_data, 32'd7);
      chk("bypass_rob", 32'(bus.iss_rob_idx), 32'd4);
      tick();

      // Fill all four entries with ops waiting on tags 0x40..0x43
      for (int i = 0; i < 4; i++) begin
         disp(3'(i), OPC_OP, 32'd0, 7'h40 + 7'(i), 1'b0, 32'd0, 7'h00, 1'b1, 32'd1);
         tick();
         chk($sformatf("fill_ready_%0d", i), 32'(bus.disp_ready), (i == 3) ? 32'd0 : 32'd1);
      end
      chk("full_no_issue", 32'(bus.iss_valid), 32'd0);
      // Dispatch attempt while full must be dropped
      disp(3'd7, OPC_OP_IMM, 32'd0, 7'h00, 1'b1, 32'd0, 7'h00, 1'b1, 32'd0);
      wb0(7'h42, 32'h55);
      tick();
      chk("full_wake_valid", 32'(bus.iss_valid), 32'd1);
      chk("full_wake_rob", 32'(bus.iss_rob_idx), 32'd2);
      chk("full_wake_rs1", bus.iss_rs1_data, 32'h55);
      chk("full_still_full", 32'(bus.disp_ready), 32'd0);
      tick();
      chk("full_ready_back", 32'(bus.disp_ready), 32'd1);
      chk("full_drop_disp", 32'(bus.iss_valid), 32'd0);

      // Three entries waiting; flush together with a ready dispatch
      disp(3'd5, OPC_OP_IMM, 32'd0, 7'h00, 1'b1, 32'd0, 7'h00, 1'b1, 32'd0);
      bus.flush = 1'b1;
      tick();
      chk("flush_iss_valid", 32'(bus.iss_valid), 32'd0);
      chk("flush_ready", 32'(bus.disp_ready), 32'd1);
      wb0(7'h40, 32'h1);
      wb1(7'h41, 32'h2);
      tick();
      chk("flush_entries_gone", 32'(bus.iss_valid), 32'd0);

      // Eligible entry still issues in the flush cycle
      disp(3'd6, OPC_OP_IMM, 32'd0, 7'h00, 1'b1, 32'h66, 7'h00, 1'b1, 32'd0);
      tick();
      bus.flush = 1'b1;
      chk("flush_cycle_issue", 32'(bus.iss_valid), 32'd1);
      chk("flush_cycle_rob", 32'(bus.iss_rob_idx), 32'd6);
      tick();
      chk("flush_after", 32'(bus.iss_valid), 32'd0);

      // Select order: rob3 lands in entry 2 before rob4 lands in entry 0
      disp(3'd1, OPC_OP, 32'd0, 7'h30, 1'b0, 32'd0, 7'h00, 1'b1, 32'd0);
      tick();
      disp(3'd2, OPC_OP, 32'd0, 7'h31, 1'b0, 32'd0, 7'h00, 1'b1, 32'd0);
      tick();
      disp(3'd3, OPC_OP, 32'd0, 7'h48, 1'b0, 32'd0, 7'h00, 1'b1, 32'd0);
      tick();
      wb0(7'h30, 32'd1);
      tick();
      chk("age_e0_issue", 32'(bus.iss_rob_idx), 32'd1);
      tick();
      disp(3'd4, OPC_OP, 32'd0, 7'h48, 1'b0, 32'd0, 7'h00, 1'b1, 32'd0);
      tick();
      wb0(7'h48, 32'h99);
      chk("age_not_yet", 32'(bus.iss_valid), 32'd0);
      tick();
`ifdef ALU_RS_AGE_SELECT_EN
      chk("sel_first", 32'(bus.iss_rob_idx), 32'd3);
      tick();
      chk("sel_second", 32'(bus.iss_rob_idx), 32'd4);
`else
      chk("sel_first", 32'(bus.iss_rob_idx), 32'd4);
      tick();
      chk("sel_second", 32'(bus.iss_rob_idx), 32'd3);
`endif
      chk("sel_second_rs1", bus.iss_rs1_data, 32'h99);
      tick();
      chk("sel_drained", 32'(bus.iss_valid), 32'd0);
      bus.flush = 1'b1;
      tick();

      // Asynchronous reset mid-operation
      disp(3'd5, OPC_OP_IMM, 32'd0, 7'h00, 1'b1, 32'h77, 7'h00, 1'b1, 32'd0);
      tick();
      chk("pre_reset_valid", 32'(bus.iss_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.iss_valid), 32'd0);
      chk("async_rst_rs1", bus.iss_rs1_data, 32'd0);
      chk("async_rst_ready", 32'(bus.disp_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
